// File: rtl/mips_reg_writeback.sv
// Write-side front end of the MIPS register file: merges single-cycle pipeline
// writebacks with buffered long-latency results (loads, mult/div) into one write port.
module mips_reg_writeback #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_wen,
  input  logic [4:0]              pipe_addr,
  input  logic [31:0]             pipe_data,
  input  logic                    ll_valid,
  output logic                    ll_ready,
  input  logic [4:0]              ll_addr,
  input  logic [31:0]             ll_data,
  input  logic [2:0]              ll_kind,
  input  logic [1:0]              ll_byte_off,
  output logic                    RegWrite,
  output logic [4:0]              WriteAddress,
  output logic [31:0]             DataIn,
  input  logic [4:0]              query_addr1,
  input  logic [4:0]              query_addr2,
  output logic                    query_hit1,
  output logic                    query_hit2,
  output logic                    stall_req,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [2:0] KIND_LB  = 3'd1;
  localparam logic [2:0] KIND_LBU = 3'd2;
  localparam logic [2:0] KIND_LH  = 3'd3;
  localparam logic [2:0] KIND_LHU = 3'd4;

  // Little-endian lane extraction; halfword selection ignores the low offset bit.
  function automatic logic [31:0] format_load(input logic [2:0]  kind,
                                              input logic [1:0]  off,
                                              input logic [31:0] raw);
    logic [31:0]        byte_sh;
    logic [31:0]        half_sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    byte_sh = raw >> {off, 3'b000};
    half_sh = raw >> {off[1], 4'b0000};
    b = byte_sh[7:0];
    h = half_sh[15:0];
    case (kind)
      KIND_LB:  r = 32'(b);
      KIND_LBU: r = {24'd0, b};
      KIND_LH:  r = 32'(h);
      KIND_LHU: r = {16'd0, h};
      default:  r = raw;
    endcase
    return r;
  endfunction

  logic [4:0]     ent_addr_q [DEPTH];
  logic [31:0]    ent_data_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           stall_q, stall_d;
  logic           regwrite_q, regwrite_d;
  logic [4:0]     waddr_q, waddr_d;
  logic [31:0]    wdata_q, wdata_d;

  logic           pipe_sel;
  logic           pop;
  logic           push;
  logic [31:0]    push_data;
  logic [DEPTH-1:0] ent_valid;

  assign pipe_sel  = pipe_wen && (pipe_addr != 5'd0);
  assign ll_ready  = (count_q < CW'(DEPTH));
  assign pop       = !pipe_sel && (count_q != '0);
  // Writes to r0 are architecturally dead, so they are acknowledged but never queued.
  assign push      = ll_valid && ll_ready && (ll_addr != 5'd0);
  assign push_data = format_load(ll_kind, ll_byte_off, ll_data);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (pipe_sel) begin
      regwrite_d = 1'b1;
      waddr_d    = pipe_addr;
      wdata_d    = pipe_data;
    end else if (pop) begin
      regwrite_d = 1'b1;
      waddr_d    = ent_addr_q[rd_ptr_q];
      wdata_d    = ent_data_q[rd_ptr_q];
    end
  end

  // The head starves only while the pipeline keeps the write port busy.
  always_comb begin
    starve_d = starve_q;
    if ((count_q == '0) || pop) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
    stall_d = (starve_d == SW'(STARVE_LIMIT));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, AW'(i) - rd_ptr_q} < count_q);
    end
  end

  always_comb begin
    query_hit1 = regwrite_q && (waddr_q == query_addr1);
    query_hit2 = regwrite_q && (waddr_q == query_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr_q[i] == query_addr1)) query_hit1 = 1'b1;
      if (ent_valid[i] && (ent_addr_q[i] == query_addr2)) query_hit2 = 1'b1;
    end
    if (query_addr1 == 5'd0) query_hit1 = 1'b0;
    if (query_addr2 == 5'd0) query_hit2 = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Entry storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= ll_addr;
      ent_data_q[wr_ptr_q] <= push_data;
    end
  end

  assign RegWrite     = regwrite_q;
  assign WriteAddress = waddr_q;
  assign DataIn       = wdata_q;
  assign stall_req    = stall_q;
  assign fifo_count   = count_q;

endmodule

// File: doc/mips_reg_writeback.md
Name: mips_reg_writeback

Overview:
- Write-side front end for the MIPS register file; produces the register file's write-enable, write-address and write-data inputs.
- Merges two write sources:
  - Main pipeline writeback: single-cycle, always has priority, never back-pressured.
  - Long-latency results: loads and mult/div, valid/ready handshake, buffered in a small FIFO.
- Formats load data (byte/half extraction, sign/zero extension).
- Reports pending-write hits so decode can stall on RAW hazards.

Parameters:
DEPTH, 4, long-latency FIFO entries (power of 2, 2..16)
STARVE_LIMIT, 8, cycles a FIFO head may wait before stall_req asserts

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
pipe_wen  in  1  pipeline write request
pipe_addr  in  5  pipeline destination register
pipe_data  in  32  pipeline write data
ll_valid  in  1  long-latency request valid
ll_ready  out  1  long-latency request accepted this cycle when high with ll_valid
ll_addr  in  5  long-latency destination register
ll_data  in  32  raw word (memory word or mult/div result)
ll_kind  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5-7 treated as LW
ll_byte_off  in  2  load address bits [1:0]
RegWrite  out  1  register file write enable
WriteAddress  out  5  register file write address
DataIn  out  32  register file write data
query_addr1  in  5  decode source register 1
query_addr2  in  5  decode source register 2
query_hit1  out  1  write to query_addr1 still pending
query_hit2  out  1  write to query_addr2 still pending
stall_req  out  1  pipeline must suppress pipe_wen so the FIFO can drain
fifo_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async): RegWrite=0, WriteAddress=0, DataIn=0, FIFO empty, fifo_count=0, starve counter=0, stall_req=0. Queued entries are discarded. Mid-transfer reset loses them; no partial write is issued.
- Outputs RegWrite/WriteAddress/DataIn are registered. Each cycle exactly one of:
  - pipe_wen=1 and pipe_addr!=0: load pipe request. Latency 1 cycle.
  - Otherwise, FIFO non-empty: pop head into output.
  - Otherwise: RegWrite=0; WriteAddress/DataIn hold their previous values.
- pipe_wen=1 with pipe_addr=0: treated as no pipe write; the FIFO may pop that cycle.
- ll_ready = (fifo_count < DEPTH). Combinational from the registered count; no same-cycle pop credit.
  - When full, ready=0 even if a pop occurs that cycle.
- Push on ll_valid && ll_ready. ll_addr=0 is accepted and discarded (no enqueue).
- No bypass. Minimum long-latency latency: accept at N, head popped at N+1, RegWrite=1 at N+2.
- Simultaneous push and pop: both take effect; count unchanged.
- Load formatting is applied at enqueue. Little-endian: byte k = ll_data[8k+7:8k].
  - LB/LBU: byte ll_byte_off, sign/zero extended.
  - LH/LHU: half ll_byte_off[1], sign/zero extended; ll_byte_off[0] ignored (alignment faults handled upstream).
  - LW and kinds 5-7: ll_data unchanged.
- FIFO is pointer-based with wrap-around modulo DEPTH; order is strictly preserved.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs; saturates at STARVE_LIMIT.
  - Clears on pop or when empty.
  - stall_req = (counter == STARVE_LIMIT), registered.
  - While stall_req=1, any pipe write still wins; pipe writes are never dropped.
- query_hitN (combinational) = addr!=0 AND (a valid FIFO entry has that address, OR RegWrite=1 with WriteAddress==addr).
- Multiple FIFO entries to the same register are all written in order; the last one wins in the register file.

Test Plan:
- Reset, then pipe_wen=1, addr=5, data=0xDEADBEEF at cycle 0 -> cycle 1: RegWrite=1, WriteAddress=5, DataIn=0xDEADBEEF; cycle 2: RegWrite=0.
- Long-latency LB, data=0x80FF7F01, off=3, addr=9, pipe idle -> two cycles later DataIn=0xFFFFFF80. Repeat with LHU, off=2 -> 0x000080FF. LH, off=0 -> 0x00007F01.
- Push 4 entries, pipe_wen held at 1 -> ll_ready=0 after the 4th, fifo_count=4. stall_req rises when the counter reaches 8. Drop pipe_wen -> entries drain in push order on consecutive cycles; ll_ready returns to 1 after the first pop.
- Queue a write to r7, query_addr1=7 -> query_hit1=1 until the cycle after RegWrite with WriteAddress=7. query_addr2=0 never hits. pipe_addr=0 and ll_addr=0 -> no RegWrite, fifo_count unchanged.
- Push 3 entries, assert rst=0 asynchronously mid-cycle -> outputs 0 immediately, fifo_count=0. After release, no stale write appears.
- Same-cycle push and pop with fifo_count=2 -> count stays 2. Wrap-around across 10 pushes/pops preserves order and data.
